// File: rtl/flopenrc_pipe.sv
// DEPTH-deep enable/reset/clear register chain with valid/ready handshake,
// bubble collapsing and synchronous flush. Define FLOPENRC_PIPE_MASK_EN to enable XOR-mask capture.
module flopenrc_pipe #(
  parameter int          WIDTH     = 64,
  parameter int          DEPTH     = 2,
  parameter logic [63:0] RESET_VAL = 64'h0412_6424_0034_3C28,
  parameter logic [63:0] MASK      = 64'h0412_6424_0034_3C28,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mask,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam logic [WIDTH-1:0] RST_W  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MASK_W = MASK[WIDTH-1:0];

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] capture_data;
  logic             accept;

  // A stage may load iff some stage at or below it is empty, or the tail drains.
  always_comb begin
    logic hole;
    hole = 1'b0;
    ld   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole  = hole | ~v[k];
      ld[k] = hole | out_ready;
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CW'(v[k]);
    end
  end

`ifdef FLOPENRC_PIPE_MASK_EN
  assign capture_data = in_mask ? (in_data ^ MASK_W) : in_data;
`else
  logic unused_mask;
  assign unused_mask  = in_mask;
  assign capture_data = in_data;
`endif

  assign in_ready  = ld[0] & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Data registers only move on a load with a valid source, so empty slots never toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RST_W;
    end else if (flush) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RST_W;
    end else begin
      if (ld[0]) begin
        v[0] <= accept;
        if (accept) d[0] <= capture_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_flopenrc_pipe.sv
// Scoreboard bench for flopenrc_pipe: in-order queue model of in-flight words,
// directed scenarios followed by randomized traffic with flushes and a mid-run reset.
module tb_flopenrc_pipe;

  localparam int          WIDTH = 64;
  localparam int          DEPTH = 2;
  localparam logic [63:0] RV    = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] MASKV = 64'h0412_6424_0034_3C28;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_mask;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int errors = 0;
  int checks = 0;
  logic [63:0] expQ[$];
  bit   modelReady = 1'b0;
  int   stallCycles = 0;

  flopenrc_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV), .MASK(MASKV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] modelWord(input logic [63:0] data, input logic mask);
`ifdef FLOPENRC_PIPE_MASK_EN
    return mask ? (data ^ MASKV) : data;
`else
    return (mask === 1'bx) ? data : data;
`endif
  endfunction

  // Monitor: compares DUT against the queue model, then retires what leaves the pipe.
  always @(negedge clk) begin
    bit expReady;
    if (reset) begin
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_out_data", out_data, RV);
      expQ.delete();
      modelReady = 1'b0;
      stallCycles = 0;
    end else begin
      expReady = !flush && ((expQ.size() < DEPTH) || out_ready);
      checkOutput("in_ready", 64'(in_ready), 64'(expReady));
      checkOutput("count", 64'(count), 64'(expQ.size()));
      if (out_valid) begin
        if (expQ.size() == 0) checkOutput("out_valid_when_empty", 64'(out_valid), 64'd0);
        else checkOutput("out_data", out_data, expQ[0]);
      end
      if (expQ.size() > 0 && !out_valid) stallCycles++;
      else stallCycles = 0;
      if (stallCycles > DEPTH - 1) begin
        checkOutput("word_stuck_stallcycles", 64'(stallCycles), 64'(DEPTH - 1));
        stallCycles = 0;
      end
      if (flush) begin
        expQ.delete();
        stallCycles = 0;
      end else if (out_valid && out_ready && expQ.size() > 0) begin
        void'(expQ.pop_front());
      end
      modelReady = expReady;
    end
  end

  // Drives one cycle of inputs and records the expected word if it will be accepted.
  task automatic applyStimulus(input logic v, input logic [63:0] data, input logic m,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = data;
    in_mask   = m;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (v && modelReady) expQ.push_back(modelWord(data, m));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_reset_count", 64'(count), 64'd0);
    checkOutput("post_reset_out_data", out_data, RV);
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Streaming: first word visible after accept edge plus one
    applyStimulus(1, 64'h1, 0, 1, 0);
    applyStimulus(1, 64'h2, 0, 1, 0);
    checkOutput("stream_not_yet_valid", 64'(out_valid), 64'd0);
    applyStimulus(1, 64'h3, 0, 1, 0);
    checkOutput("stream_w1", out_data, 64'h1);
    applyStimulus(0, 64'h0, 0, 1, 0);
    checkOutput("stream_w2", out_data, 64'h2);
    applyStimulus(0, 64'h0, 0, 1, 0);
    checkOutput("stream_w3", out_data, 64'h3);
    applyStimulus(0, 64'h0, 0, 1, 0);
    checkOutput("stream_drained", 64'(out_valid), 64'd0);

    // Fill under backpressure, then release
    applyStimulus(1, 64'hA, 0, 0, 0);
    applyStimulus(1, 64'hB, 0, 0, 0);
    applyStimulus(0, 64'h0, 0, 0, 0);
    checkOutput("full_count", 64'(count), 64'd2);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 64'h0, 0, 1, 0);
    checkOutput("release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("release_out_data", out_data, 64'hA);
    repeat (3) applyStimulus(0, 64'h0, 0, 1, 0);

    // Bubble collapse while downstream stalls
    applyStimulus(1, 64'hC, 0, 0, 0);
    applyStimulus(0, 64'h0, 0, 0, 0);
    applyStimulus(0, 64'h0, 0, 0, 0);
    checkOutput("bubble_count1", 64'(count), 64'd1);
    checkOutput("bubble_out_data", out_data, 64'hC);
    applyStimulus(1, 64'hD, 0, 0, 0);
    applyStimulus(0, 64'h0, 0, 0, 0);
    checkOutput("bubble_count2", 64'(count), 64'd2);
    repeat (3) applyStimulus(0, 64'h0, 0, 1, 0);

    // Masked capture of zero
    applyStimulus(1, 64'h0, 1, 1, 0);
    applyStimulus(0, 64'h0, 0, 1, 0);
    applyStimulus(0, 64'h0, 0, 1, 0);
`ifdef FLOPENRC_PIPE_MASK_EN
    checkOutput("mask_out_data", out_data, MASKV);
`else
    checkOutput("mask_out_data", out_data, 64'h0);
`endif
    repeat (2) applyStimulus(0, 64'h0, 0, 1, 0);

    // Flush a full pipe with a word offered
    applyStimulus(1, 64'h11, 0, 0, 0);
    applyStimulus(1, 64'h22, 0, 0, 0);
    applyStimulus(1, 64'h33, 0, 0, 1);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 64'h0, 0, 0, 0);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_out_data", out_data, RV);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) doReset();
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    repeat (DEPTH + 2) applyStimulus(0, 64'h0, 0, 1, 0);
    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
